mem_access_stage: RTL

Memory-access (MEM) stage of the 5-stage RISC-V pipeline: sits between the EX/MEM register and the MEM/WB register. It turns a load/store from EX into a request/ready handshake on the data-memory port and produces the formatted load data that the MEM/WB register captures. It also raises the pipeline stall while the access is outstanding. Misaligned, illegal and timed-out accesses are reported, not trapped.

---
 rtl/rv_pkg.sv | 37 +++
 rtl/lsu_align.sv | 65 ++++++
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the memory-access stage: funct3 codes,
// MEM-stage FSM states, error cause codes and the default request timeout.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic legal_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated data, load
// byte/half selection with sign or zero extension, and access fault flags.
module lsu_align
  import rv_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    illegal    = (is_load & is_store) |
                 (is_load & ~legal_load(funct3)) |
                 (is_store & ~legal_store(funct3));
    misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                 ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));

    wstrb = 4'b0000;
    wdata = 32'h0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {4{st_data[7:0]}};
        end
        F3_SH: begin
          wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{st_data[15:0]}};
        end
        F3_SW: begin
          wstrb = 4'b1111;
          wdata = st_data;
        end
        default: begin
          wstrb = 4'b0000;
          wdata = 32'h0;
        end
      endcase
    end

    case (funct3)
      F3_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ld_ext = {24'h0, byte_sel};
      F3_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ld_ext = {16'h0, half_sel};
      F3_LW:   ld_ext = rdata;
      default: ld_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32I pipeline: turns EX/MEM loads/stores into a
// req/ready data-memory transaction, stalls upstream and formats load data.
module mem_access_stage
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  dbg_state
);

  // Memory handshake: dmem_req is raised on REQ entry and held, with
  // addr/we/wstrb/wdata stable, until the first cycle dmem_ready is high;
  // that cycle both accepts the request and returns dmem_rdata.

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        load_q;
  logic        store_q;

  logic        access;
  logic        in_idle;
  logic        al_load;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;
  logic        al_misaligned;
  logic        al_illegal;

  assign access  = valid & (mem_read | mem_write);
  assign in_idle = (state == ST_IDLE);

  // Live EX/MEM fields are decoded in IDLE; latched ones format the read data.
  assign al_load  = in_idle ? mem_read  : load_q;
  assign al_store = in_idle ? mem_write : store_q;
  assign al_f3    = in_idle ? funct3    : f3_q;
  assign al_lo    = in_idle ? addr[1:0] : lo_q;

  lsu_align u_align (
    .is_load    (al_load),
    .is_store   (al_store),
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .st_data    (st_data),
    .rdata      (dmem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .ld_ext     (al_ld),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign stall     = ~rst & ((in_idle & access) | (state == ST_REQ));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tmo_cnt    <= 16'h0;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      ld_data    <= 32'h0;
      err        <= 1'b0;
      err_cause  <= CAUSE_NONE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wstrb <= 4'b0000;
      dmem_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            f3_q    <= funct3;
            lo_q    <= addr[1:0];
            load_q  <= mem_read;
            store_q <= mem_write;
            if (al_illegal) begin
              state     <= ST_DONE;
              err       <= 1'b1;
              err_cause <= CAUSE_ILLEGAL;
              if (mem_read) ld_data <= 32'h0;
            end else if (al_misaligned) begin
              state     <= ST_DONE;
              err       <= 1'b1;
              err_cause <= CAUSE_MISALIGN;
              if (mem_read) ld_data <= 32'h0;
            end else begin
              state      <= ST_REQ;
              tmo_cnt    <= 16'h0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_wstrb <= al_wstrb;
              dmem_wdata <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          // A ready in the final allowed cycle still completes normally.
          if (dmem_ready) begin
            state    <= ST_DONE;
            dmem_req <= 1'b0;
            if (load_q) ld_data <= al_ld;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= ST_DONE;
            dmem_req  <= 1'b0;
            err       <= 1'b1;
            err_cause <= CAUSE_TIMEOUT;
            if (load_q) ld_data <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          err       <= 1'b0;
          err_cause <= CAUSE_NONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
